// File: rtl/cv32e40p_cg_pkg.sv
// Shared types and defaults for the CV32E40P domain clock-gate controller.
package cv32e40p_cg_pkg;

    // Per-domain controller state
    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_e;

    // Default hysteresis settings
    localparam int unsigned CG_IDLE_CYCLES_DEFAULT = 8;
    localparam int unsigned CG_WAKE_CYCLES_DEFAULT = 2;

    // Gated-cycle statistics counter
    localparam int unsigned CG_STATS_W = 32;
    typedef logic [CG_STATS_W-1:0] cg_stats_t;
    localparam cg_stats_t CG_STATS_MAX = '1;

    function automatic int unsigned cg_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cv32e40p_rst_sync.sv
// Reset-release synchroniser shared by all gated domains, with the DFT
// bypass that hands the domain reset to the scan controller.
module cv32e40p_rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic test_mode,
    input  logic scan_rst_n,
    output logic domain_rst_n,
    output logic release_next
);

    logic [STAGES-1:0] sync_reg;

    // Shift in ones; any reset assertion clears the chain immediately
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], 1'b1};
        end
    end

    // The last-but-one stage tells the FSMs that the reset lifts on the
    // coming edge, so they leave RESET on the same edge rst_n rises.
    assign release_next = sync_reg[STAGES-2];
    assign domain_rst_n = test_mode ? scan_rst_n : sync_reg[STAGES-1];

endmodule

// File: rtl/cv32e40p_domain_cg_ctrl.sv
// Clock-gate and reset controller for NUM_DOMAINS gated clock domains.
// Optional feature: define CV32E40P_CG_STATS_EN to build per-domain
// gated-cycle counters; otherwise gated_cycles_o is tied to zero.
module cv32e40p_domain_cg_ctrl
    import cv32e40p_cg_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS     = 2,
    parameter int unsigned IDLE_CYCLES     = CG_IDLE_CYCLES_DEFAULT,
    parameter int unsigned WAKE_CYCLES     = CG_WAKE_CYCLES_DEFAULT,
    parameter int unsigned RST_SYNC_STAGES = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               test_mode_i,
    input  logic                               scan_rst_ni,
    input  logic [NUM_DOMAINS-1:0]             busy_i,
    input  logic [NUM_DOMAINS-1:0]             req_i,
    output logic [NUM_DOMAINS-1:0]             gnt_o,
    output logic [NUM_DOMAINS-1:0]             clk_en_o,
    output logic [NUM_DOMAINS-1:0]             rst_n_o,
    output logic [NUM_DOMAINS-1:0]             gated_o,
    output logic [NUM_DOMAINS-1:0][CG_STATS_W-1:0] gated_cycles_o
);

    localparam int unsigned CNT_W = $clog2(cg_max(IDLE_CYCLES, WAKE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if (IDLE_CYCLES < 1) begin : g_chk_idle
        $error("IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 1) begin : g_chk_wake
        $error("WAKE_CYCLES must be >= 1");
    end
    if (RST_SYNC_STAGES < 2) begin : g_chk_sync
        $error("RST_SYNC_STAGES must be >= 2");
    end
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_chk_dom
        $error("NUM_DOMAINS must be in 1..8");
    end

    logic domain_rst_n;
    logic release_next;

    cv32e40p_rst_sync #(
        .STAGES (RST_SYNC_STAGES)
    ) u_rst_sync (
        .clk          (clk_i),
        .arst_n       (rst_ni),
        .test_mode    (test_mode_i),
        .scan_rst_n   (scan_rst_ni),
        .domain_rst_n (domain_rst_n),
        .release_next (release_next)
    );

    assign rst_n_o = {NUM_DOMAINS{domain_rst_n}};

    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
        cg_state_e        state_reg, state_next;
        logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
        logic [CNT_W-1:0] wake_cnt_reg, wake_cnt_next;
        logic             active;
        logic             clk_en, gated, gnt;

        assign active = busy_i[gi] | req_i[gi];

        // State and counter registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_reg    <= RESET;
                idle_cnt_reg <= '0;
                wake_cnt_reg <= '0;
            end else begin
                state_reg    <= state_next;
                idle_cnt_reg <= idle_cnt_next;
                wake_cnt_reg <= wake_cnt_next;
            end
        end

        // Next state: idle hysteresis in RUN, fixed wake-up delay in WAKE
        always_comb begin
            state_next    = state_reg;
            idle_cnt_next = idle_cnt_reg;
            wake_cnt_next = wake_cnt_reg;
            case (state_reg)
                RESET: begin
                    idle_cnt_next = '0;
                    wake_cnt_next = '0;
                    if (release_next) state_next = RUN;
                end
                RUN: begin
                    // Activity (including a request arriving on the expiry
                    // cycle) always keeps the domain running.
                    if (active) begin
                        idle_cnt_next = '0;
                    end else if (idle_cnt_reg == IDLE_LAST) begin
                        state_next    = GATED;
                        idle_cnt_next = '0;
                    end else if (idle_cnt_reg != CNT_MAX) begin
                        idle_cnt_next = idle_cnt_reg + CNT_W'(1);
                    end
                end
                GATED: begin
                    if (active) begin
                        state_next    = WAKE;
                        wake_cnt_next = '0;
                    end
                end
                WAKE: begin
                    // Completes even if the request is withdrawn meanwhile
                    if (wake_cnt_reg == WAKE_LAST) begin
                        state_next    = RUN;
                        wake_cnt_next = '0;
                        idle_cnt_next = '0;
                    end else if (wake_cnt_reg != CNT_MAX) begin
                        wake_cnt_next = wake_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = RESET;
            endcase
        end

        // Outputs from registered state, with the test-mode override on top
        always_comb begin
            clk_en = 1'b1;
            gated  = 1'b0;
            gnt    = 1'b0;
            case (state_reg)
                GATED: begin
                    clk_en = 1'b0;
                    gated  = 1'b1;
                end
                RUN:     gnt = req_i[gi];
                default: ;
            endcase
            if (test_mode_i) begin
                clk_en = 1'b1;
                gnt    = req_i[gi];
            end
        end

        assign clk_en_o[gi] = clk_en;
        assign gated_o[gi]  = gated;
        assign gnt_o[gi]    = gnt;

`ifdef CV32E40P_CG_STATS_EN
        cg_stats_t stats_reg;

        // Saturating count of functional-mode cycles spent gated
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stats_reg <= '0;
            end else if (state_reg == GATED && !test_mode_i && stats_reg != CG_STATS_MAX) begin
                stats_reg <= stats_reg + cg_stats_t'(1);
            end
        end

        assign gated_cycles_o[gi] = stats_reg;
`else
        assign gated_cycles_o[gi] = '0;
`endif
    end

endmodule

// File: tb/tb_cv32e40p_domain_cg_ctrl.sv
// Self-checking bench for cv32e40p_domain_cg_ctrl: directed scenarios plus a
// randomized run, all checked against a cycle-level behavioural model.
module tb_cv32e40p_domain_cg_ctrl;

    localparam int ND    = 2;
    localparam int IDLE  = 8;
    localparam int WAKE  = 2;
    localparam int SYNC  = 2;
`ifdef CV32E40P_CG_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b1;
    logic                     test_mode_i = 1'b0;
    logic                     scan_rst_ni = 1'b1;
    logic [ND-1:0]            busy_i = '0;
    logic [ND-1:0]            req_i = '0;
    logic [ND-1:0]            gnt_o, clk_en_o, rst_n_o, gated_o;
    logic [ND-1:0][31:0]      gated_cycles_o;

    int checks = 0;
    int errors = 0;

    cv32e40p_domain_cg_ctrl #(
        .NUM_DOMAINS     (ND),
        .IDLE_CYCLES     (IDLE),
        .WAKE_CYCLES     (WAKE),
        .RST_SYNC_STAGES (SYNC)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .test_mode_i    (test_mode_i),
        .scan_rst_ni    (scan_rst_ni),
        .busy_i         (busy_i),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .clk_en_o       (clk_en_o),
        .rst_n_o        (rst_n_o),
        .gated_o        (gated_o),
        .gated_cycles_o (gated_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model ----------------
    int          m_rel;             // edges seen with reset released (saturates at SYNC)
    int          m_idle[ND];        // consecutive idle cycles while running
    bit          m_asleep[ND];      // clock is stopped
    int          m_wake_left[ND];   // edges remaining before the domain is usable
    bit          m_run[ND];         // domain usable
    logic [31:0] m_stats[ND];

    logic [ND-1:0]       exp_clk_en, exp_rst_n, exp_gnt, exp_gated;
    logic [ND-1:0][31:0] exp_stats;

    function automatic void model_reset();
        m_rel = 0;
        for (int d = 0; d < ND; d++) begin
            m_idle[d] = 0; m_asleep[d] = 0; m_wake_left[d] = 0; m_run[d] = 0; m_stats[d] = '0;
        end
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    function automatic void model_edge();
        bit was_alive;
        bit act;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        was_alive = (m_rel >= SYNC);
        if (m_rel < SYNC) m_rel++;
        for (int d = 0; d < ND; d++) begin
            act = busy_i[d] | req_i[d];
            if (m_asleep[d] && !test_mode_i && m_stats[d] != 32'hFFFF_FFFF) m_stats[d] = m_stats[d] + 1;
            if (!was_alive) begin
                if (m_rel >= SYNC) begin m_run[d] = 1; m_idle[d] = 0; end
            end else if (m_run[d]) begin
                if (act) m_idle[d] = 0;
                else begin
                    m_idle[d]++;
                    if (m_idle[d] == IDLE) begin m_run[d] = 0; m_asleep[d] = 1; m_idle[d] = 0; end
                end
            end else if (m_asleep[d]) begin
                if (act) begin m_asleep[d] = 0; m_wake_left[d] = WAKE; end
            end else if (m_wake_left[d] > 0) begin
                m_wake_left[d]--;
                if (m_wake_left[d] == 0) m_run[d] = 1;
            end
        end
    endfunction

    function automatic void model_outputs();
        for (int d = 0; d < ND; d++) begin
            exp_clk_en[d] = test_mode_i | ~m_asleep[d];
            exp_rst_n[d]  = test_mode_i ? scan_rst_ni : (m_rel >= SYNC);
            exp_gnt[d]    = test_mode_i ? req_i[d] : (req_i[d] & m_run[d]);
            exp_gated[d]  = m_asleep[d];
            exp_stats[d]  = STATS_EN ? m_stats[d] : 32'd0;
        end
    endfunction

    // One clock edge; outputs are settled and expectations refreshed on return
    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        model_outputs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_ni = 1'b0;
        req_i = '1;
        model_reset();
        #1 model_outputs();
        checks++; if (clk_en_o !== {ND{1'b1}}) begin errors++; $display("FAIL reset_clk_en: got %b want %b", clk_en_o, {ND{1'b1}}); end
        checks++; if (rst_n_o !== '0) begin errors++; $display("FAIL reset_rst_n: got %b want 0", rst_n_o); end
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
        checks++; if (gated_o !== '0) begin errors++; $display("FAIL reset_gated: got %b want 0", gated_o); end
        checks++; if (gated_cycles_o !== '0) begin errors++; $display("FAIL reset_stats: got %h want 0", gated_cycles_o); end
        step(); step();
        req_i = '0;
        rst_ni = 1'b1;
        step();
        checks++; if (rst_n_o !== '0) begin errors++; $display("FAIL release_edge1_rst_n: got %b want 0", rst_n_o); end
        step();
        checks++; if (rst_n_o !== {ND{1'b1}}) begin errors++; $display("FAIL release_edge2_rst_n: got %b want %b", rst_n_o, {ND{1'b1}}); end
        checks++; if (clk_en_o !== {ND{1'b1}} || gnt_o !== '0) begin errors++; $display("FAIL release_outputs: clk_en %b gnt %b want all-1 / 0", clk_en_o, gnt_o); end
        req_i = '1;
        #1 model_outputs();
        checks++; if (gnt_o !== {ND{1'b1}}) begin errors++; $display("FAIL release_run_gnt: got %b want %b", gnt_o, {ND{1'b1}}); end
        req_i = '0;
        $display("test_reset done");
    endtask

    task automatic test_idle_gating();
        busy_i = '1;
        step();
        busy_i = 2'b10;
        for (int i = 0; i < IDLE; i++) begin
            step();
            checks++;
            if (clk_en_o[0] !== (i < IDLE - 1) || clk_en_o !== exp_clk_en || gated_o !== exp_gated) begin
                errors++; $display("FAIL idle_gating[%0d]: clk_en %b gated %b want %b %b", i, clk_en_o, gated_o, exp_clk_en, exp_gated);
            end
        end
        checks++; if (gated_o !== 2'b01 || clk_en_o !== 2'b10) begin errors++; $display("FAIL idle_gated_final: gated %b clk_en %b want 01 10", gated_o, clk_en_o); end
        $display("test_idle_gating done");
    endtask

    task automatic test_wake();
        // domain 0 is gated on entry; request held through the wake-up
        req_i = 2'b01;
        #1 model_outputs();
        checks++; if (gnt_o[0] !== 1'b0) begin errors++; $display("FAIL wake_gnt_while_gated: got %b want 0", gnt_o[0]); end
        for (int i = 0; i <= WAKE; i++) begin
            step();
            checks++;
            if (clk_en_o[0] !== 1'b1 || gnt_o[0] !== (i == WAKE) || gnt_o !== exp_gnt) begin
                errors++; $display("FAIL wake_seq[%0d]: clk_en %b gnt %b want gnt %b", i, clk_en_o, gnt_o, exp_gnt);
            end
        end
        req_i = '0;
        for (int i = 0; i < IDLE; i++) step();
        checks++; if (gated_o[0] !== 1'b1) begin errors++; $display("FAIL wake_regate: got %b want 1", gated_o[0]); end
        // request pulsed for one cycle only
        req_i = 2'b01;
        step();
        req_i = '0;
        for (int i = 0; i < WAKE; i++) step();
        req_i = 2'b01;
        #1 model_outputs();
        checks++; if (gated_o[0] !== 1'b0 || gnt_o[0] !== 1'b1 || gnt_o !== exp_gnt) begin errors++; $display("FAIL wake_dropped_req: gated %b gnt %b want 0 1", gated_o[0], gnt_o[0]); end
        req_i = '0;
        $display("test_wake done");
    endtask

    task automatic test_race();
        busy_i = '1;
        step();
        busy_i = 2'b10;
        for (int i = 0; i < IDLE - 1; i++) step();
        req_i = 2'b01;
        #1 model_outputs();
        checks++; if (gnt_o[0] !== 1'b1) begin errors++; $display("FAIL race_gnt: got %b want 1", gnt_o[0]); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (clk_en_o[0] !== 1'b1 || gated_o !== exp_gated) begin errors++; $display("FAIL race_stay_run[%0d]: clk_en %b gated %b", i, clk_en_o, gated_o); end
        end
        req_i = '0;
        $display("test_race done");
    endtask

    task automatic test_test_mode();
        busy_i = 2'b10;
        for (int i = 0; i < IDLE + 3; i++) step();
        test_mode_i = 1'b1;
        scan_rst_ni = 1'b0;
        req_i = 2'b01;
        #1 model_outputs();
        checks++; if (clk_en_o !== {ND{1'b1}}) begin errors++; $display("FAIL tm_clk_en: got %b want all-1", clk_en_o); end
        checks++; if (rst_n_o !== '0) begin errors++; $display("FAIL tm_scan_rst_low: got %b want 0", rst_n_o); end
        checks++; if (gnt_o !== req_i) begin errors++; $display("FAIL tm_gnt: got %b want %b", gnt_o, req_i); end
        req_i = '0;
        scan_rst_ni = 1'b1;
        #1 model_outputs();
        checks++; if (rst_n_o !== {ND{1'b1}}) begin errors++; $display("FAIL tm_scan_rst_high: got %b want all-1", rst_n_o); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (gated_cycles_o !== exp_stats || gated_o[0] !== 1'b1) begin errors++; $display("FAIL tm_frozen: stats %h gated %b want %h 1", gated_cycles_o, gated_o, exp_stats); end
        test_mode_i = 1'b0;
        #1 model_outputs();
        checks++; if (clk_en_o[0] !== 1'b0) begin errors++; $display("FAIL tm_exit: clk_en %b want 0", clk_en_o[0]); end
        step();
        checks++; if (gated_cycles_o !== exp_stats) begin errors++; $display("FAIL tm_resume_stats: got %h want %h", gated_cycles_o, exp_stats); end
        $display("test_test_mode done");
    endtask

    task automatic test_mid_reset();
        busy_i = 2'b10;
        req_i = 2'b01;
        step();
        checks++; if (gated_o[0] !== 1'b0 || gnt_o[0] !== 1'b0 || clk_en_o[0] !== 1'b1) begin errors++; $display("FAIL midrst_in_wake: gated %b gnt %b clk_en %b", gated_o[0], gnt_o[0], clk_en_o[0]); end
        rst_ni = 1'b0;
        model_reset();
        #1 model_outputs();
        checks++; if (rst_n_o !== '0 || clk_en_o !== {ND{1'b1}} || gnt_o !== '0) begin errors++; $display("FAIL midrst_immediate: rst_n %b clk_en %b gnt %b", rst_n_o, clk_en_o, gnt_o); end
        checks++; if (gated_cycles_o !== '0) begin errors++; $display("FAIL midrst_stats: got %h want 0", gated_cycles_o); end
        step();
        rst_ni = 1'b1;
        req_i = '0;
        step(); step();
        checks++; if (rst_n_o !== {ND{1'b1}} || gated_o !== '0 || clk_en_o !== {ND{1'b1}}) begin errors++; $display("FAIL midrst_release: rst_n %b gated %b clk_en %b", rst_n_o, gated_o, clk_en_o); end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < ND; d++) begin
                busy_i[d] = ($urandom_range(0, 9) == 0);
                req_i[d]  = ($urandom_range(0, 11) == 0);
            end
            if ($urandom_range(0, 39) == 0) test_mode_i = ~test_mode_i;
            scan_rst_ni = $urandom_range(0, 1);
            #1 model_outputs();
            checks++;
            if (gnt_o !== exp_gnt || clk_en_o !== exp_clk_en || rst_n_o !== exp_rst_n) begin
                errors++; bad++;
                $display("FAIL random_comb[%0d]: gnt %b/%b clk_en %b/%b rst_n %b/%b", n, gnt_o, exp_gnt, clk_en_o, exp_clk_en, rst_n_o, exp_rst_n);
            end
            step();
            checks++;
            if (gated_o !== exp_gated || clk_en_o !== exp_clk_en || gated_cycles_o !== exp_stats) begin
                errors++; bad++;
                $display("FAIL random_seq[%0d]: gated %b/%b clk_en %b/%b stats %h/%h", n, gated_o, exp_gated, clk_en_o, exp_clk_en, gated_cycles_o, exp_stats);
            end
            if (bad > 10) break;
        end
        test_mode_i = 1'b0;
        scan_rst_ni = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_gating();
        test_wake();
        test_race();
        test_test_mode();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
